// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   owner_t     : which requester owns the port / an in-flight read
//   arb_state_t : arbiter sequencer states
//   GNT_*       : bit positions in the one-hot grant vector
package mem_arb_pkg;

  localparam int unsigned MAX_RD_LAT = 3;
  localparam int unsigned CNT_W      = $clog2(MAX_RD_LAT + 1);

  localparam int unsigned GNT_LD = 0;
  localparam int unsigned GNT_D  = 1;
  localparam int unsigned GNT_F  = 2;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LD,
    OWN_D,
    OWN_F
  } owner_t;

  typedef enum logic {
    ST_IDLE,
    ST_RD_WAIT
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection for the memory port arbiter.
// Ports:
//   i_en      : grants allowed this cycle (arbiter idle)
//   i_ld_req  : loader request, absolute priority
//   i_d_req   : data-stage request
//   i_f_req   : fetch request
//   i_last_d  : round-robin history, 1 = D won the last D/F grant
//   o_gnt     : one-hot grant vector, indexed by GNT_LD/GNT_D/GNT_F
//   o_owner   : winner encoded as owner_t (OWN_NONE when nothing granted)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_en,
  input  logic       i_ld_req,
  input  logic       i_d_req,
  input  logic       i_f_req,
  input  logic       i_last_d,
  output logic [2:0] o_gnt,
  output owner_t     o_owner
);

  always_comb begin
    o_gnt   = '0;
    o_owner = OWN_NONE;
    if (i_en) begin
      if (i_ld_req) begin
        o_gnt[GNT_LD] = 1'b1;
        o_owner       = OWN_LD;
      end else if (i_d_req && (!i_f_req || !i_last_d)) begin
        // D wins when alone, or when contending and F went last
        o_gnt[GNT_D] = 1'b1;
        o_owner      = OWN_D;
      end else if (i_f_req) begin
        o_gnt[GNT_F] = 1'b1;
        o_owner      = OWN_F;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM among the program loader (LD), the data
// stage (D) and instruction fetch (F). Grants are combinational in the
// idle state; reads hold the port for RD_LAT+1 cycles and the returning
// data is steered to the requester that issued it.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   ld_req/ld_addr/ld_wdata/ld_gnt: loader write channel
//   d_req/d_we/d_addr/d_wdata     : data request (store or load)
//   d_gnt/d_rvalid/d_rdata        : data grant and load return
//   f_req/f_addr                  : fetch read request
//   f_gnt/f_rvalid/f_rdata        : fetch grant and instruction return
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata           : memory macro port
//   cpu_stall                     : hold PC/pipeline
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  arb_state_t       r_state, w_state_nxt;
  owner_t           r_owner, w_owner_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_last_d, w_last_d_nxt;

  logic [2:0]       w_gnt;
  owner_t           w_pick;
  logic             w_idle;

  assign w_idle = (r_state == ST_IDLE);

  mem_arb_pick u_pick (
    .i_en     (w_idle),
    .i_ld_req (ld_req),
    .i_d_req  (d_req),
    .i_f_req  (f_req),
    .i_last_d (r_last_d),
    .o_gnt    (w_gnt),
    .o_owner  (w_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWN_NONE;
      r_cnt    <= '0;
      r_last_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last_d <= w_last_d_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_cnt_nxt    = r_cnt;
    w_last_d_nxt = r_last_d;

    ld_gnt    = w_gnt[GNT_LD];
    d_gnt     = w_gnt[GNT_D];
    f_gnt     = w_gnt[GNT_F];
    d_rvalid  = 1'b0;
    f_rvalid  = 1'b0;
    d_rdata   = mem_rdata;
    f_rdata   = mem_rdata;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Memory port mux; w_pick is OWN_NONE outside IDLE
    case (w_pick)
      OWN_LD: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      OWN_D: begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      OWN_F: begin
        mem_en    = 1'b1;
        mem_addr  = f_addr;
      end
      default: ;
    endcase

    case (r_state)
      ST_IDLE: begin
        if (w_pick == OWN_D) w_last_d_nxt = 1'b1;
        if (w_pick == OWN_F) w_last_d_nxt = 1'b0;
        if ((w_pick == OWN_F) || ((w_pick == OWN_D) && !d_we)) begin
          w_owner_nxt = w_pick;
          w_cnt_nxt   = CNT_W'(RD_LAT);
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          d_rvalid    = (r_owner == OWN_D);
          f_rvalid    = (r_owner == OWN_F);
          w_owner_nxt = OWN_NONE;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    cpu_stall = (f_req && !f_gnt) || (d_req && !d_gnt) ||
                (r_state == ST_RD_WAIT) || ld_req;

    // Reset forces every output low, including the rdata pass-throughs
    if (rst) begin
      ld_gnt    = 1'b0;
      d_gnt     = 1'b0;
      f_gnt     = 1'b0;
      d_rvalid  = 1'b0;
      f_rvalid  = 1'b0;
      d_rdata   = '0;
      f_rdata   = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with RD_LAT=1,2,3,
// each attached to a behavioural RAM with matching read latency.
module tb_mem_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst      [3];
  logic          ld_req   [3];
  logic [AW-1:0] ld_addr  [3];
  logic [DW-1:0] ld_wdata [3];
  logic          ld_gnt   [3];
  logic          d_req    [3];
  logic          d_we     [3];
  logic [AW-1:0] d_addr   [3];
  logic [DW-1:0] d_wdata  [3];
  logic          d_gnt    [3];
  logic          d_rvalid [3];
  logic [DW-1:0] d_rdata  [3];
  logic          f_req    [3];
  logic [AW-1:0] f_addr   [3];
  logic          f_gnt    [3];
  logic          f_rvalid [3];
  logic [DW-1:0] f_rdata  [3];
  logic          mem_en   [3];
  logic          mem_we   [3];
  logic [AW-1:0] mem_addr [3];
  logic [DW-1:0] mem_wdata[3];
  logic [DW-1:0] mem_rdata[3];
  logic          cpu_stall[3];

  int errors;
  int checks;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(g + 1)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .ld_req    (ld_req[g]),
      .ld_addr   (ld_addr[g]),
      .ld_wdata  (ld_wdata[g]),
      .ld_gnt    (ld_gnt[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_gnt     (d_gnt[g]),
      .d_rvalid  (d_rvalid[g]),
      .d_rdata   (d_rdata[g]),
      .f_req     (f_req[g]),
      .f_addr    (f_addr[g]),
      .f_gnt     (f_gnt[g]),
      .f_rvalid  (f_rvalid[g]),
      .f_rdata   (f_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .cpu_stall (cpu_stall[g])
    );

    // RAM model: data appears g+1 cycles after a read enable
    logic [DW-1:0] mem  [0:(1<<AW)-1];
    logic [DW-1:0] pipe [1:3];
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
      pipe[1] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : '0;
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end
    assign mem_rdata[g] = pipe[g + 1];
  end

  task automatic chk(input string tag, input logic ok,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_d;
    logic [7:0] exp_f;
    errors = 0;
    checks = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;      ld_req[i] = 1'b0;  ld_addr[i] = '0;
      ld_wdata[i] = '0;   d_req[i] = 1'b0;   d_we[i] = 1'b0;
      d_addr[i] = '0;     d_wdata[i] = '0;   f_req[i] = 1'b0;
      f_addr[i] = '0;
    end
    // Requests while in reset must not leak to any output
    ld_req[0] = 1'b1; d_req[0] = 1'b1; f_req[0] = 1'b1;
    ld_addr[0] = 14'h3FFF; f_addr[0] = 14'h0123;
    smp(); smp();
    chk("rst_ld_gnt",  ld_gnt[0] === 1'b0,      ld_gnt[0],    1'b0);
    chk("rst_d_gnt",   d_gnt[0] === 1'b0,       d_gnt[0],     1'b0);
    chk("rst_f_gnt",   f_gnt[0] === 1'b0,       f_gnt[0],     1'b0);
    chk("rst_mem_en",  mem_en[0] === 1'b0,      mem_en[0],    1'b0);
    chk("rst_mem_we",  mem_we[0] === 1'b0,      mem_we[0],    1'b0);
    chk("rst_addr",    mem_addr[0] === 14'h0,   mem_addr[0],  14'h0);
    chk("rst_stall",   cpu_stall[0] === 1'b0,   cpu_stall[0], 1'b0);
    chk("rst_d_rdata", d_rdata[0] === 32'h0,    d_rdata[0],   32'h0);
    chk("rst_f_rdata", f_rdata[0] === 32'h0,    f_rdata[0],   32'h0);
    cyc();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    ld_req[0] = 1'b0; d_req[0] = 1'b0; f_req[0] = 1'b0;
    smp();
    chk("idle_mem_en", mem_en[0] === 1'b0,      mem_en[0],    1'b0);
    chk("idle_addr",   mem_addr[0] === 14'h0,   mem_addr[0],  14'h0);
    chk("idle_wdata",  mem_wdata[0] === 32'h0,  mem_wdata[0], 32'h0);
    chk("idle_stall",  cpu_stall[0] === 1'b0,   cpu_stall[0], 1'b0);

    // RD_LAT=1: preload via loader, then fetch read
    cyc();
    ld_req[0] = 1'b1; ld_addr[0] = 14'h010; ld_wdata[0] = 32'h2008_0005;
    smp();
    chk("pre_ld_gnt", ld_gnt[0] === 1'b1,             ld_gnt[0],    1'b1);
    chk("pre_we",     mem_we[0] === 1'b1,             mem_we[0],    1'b1);
    chk("pre_addr",   mem_addr[0] === 14'h010,        mem_addr[0],  14'h010);
    chk("pre_wdata",  mem_wdata[0] === 32'h2008_0005, mem_wdata[0], 32'h2008_0005);
    chk("pre_stall",  cpu_stall[0] === 1'b1,          cpu_stall[0], 1'b1);
    cyc();
    ld_req[0] = 1'b0; f_req[0] = 1'b1; f_addr[0] = 14'h010;
    smp();
    chk("l1_f_gnt",  f_gnt[0] === 1'b1,        f_gnt[0],     1'b1);
    chk("l1_mem_en", mem_en[0] === 1'b1,       mem_en[0],    1'b1);
    chk("l1_mem_we", mem_we[0] === 1'b0,       mem_we[0],    1'b0);
    chk("l1_addr",   mem_addr[0] === 14'h010,  mem_addr[0],  14'h010);
    chk("l1_stall0", cpu_stall[0] === 1'b0,    cpu_stall[0], 1'b0);
    cyc();
    f_req[0] = 1'b0;
    smp();
    chk("l1_f_rvalid", f_rvalid[0] === 1'b1,          f_rvalid[0],  1'b1);
    chk("l1_f_rdata",  f_rdata[0] === 32'h2008_0005,  f_rdata[0],   32'h2008_0005);
    chk("l1_d_rvalid", d_rvalid[0] === 1'b0,          d_rvalid[0],  1'b0);
    chk("l1_stall1",   cpu_stall[0] === 1'b1,         cpu_stall[0], 1'b1);
    chk("l1_wait_en",  mem_en[0] === 1'b0,            mem_en[0],    1'b0);
    cyc();
    f_req[0] = 1'b1; f_addr[0] = 14'h3FFF;
    smp();
    chk("l1_regrant", f_gnt[0] === 1'b1,        f_gnt[0],    1'b1);
    chk("l1_maxaddr", mem_addr[0] === 14'h3FFF, mem_addr[0], 14'h3FFF);
    cyc();
    f_req[0] = 1'b0;
    smp();
    chk("l1_rvalid2", f_rvalid[0] === 1'b1, f_rvalid[0], 1'b1);
    cyc();

    // RD_LAT=2: D store then load of the same word
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 14'h100; d_wdata[1] = 32'hDEAD_BEEF;
    smp();
    chk("st_d_gnt", d_gnt[1] === 1'b1,            d_gnt[1],     1'b1);
    chk("st_en",    mem_en[1] === 1'b1,           mem_en[1],    1'b1);
    chk("st_we",    mem_we[1] === 1'b1,           mem_we[1],    1'b1);
    chk("st_addr",  mem_addr[1] === 14'h100,      mem_addr[1],  14'h100);
    chk("st_wdata", mem_wdata[1] === 32'hDEAD_BEEF, mem_wdata[1], 32'hDEAD_BEEF);
    chk("st_stall", cpu_stall[1] === 1'b0,        cpu_stall[1], 1'b0);
    cyc();
    d_we[1] = 1'b0;
    smp();
    chk("ld_d_gnt", d_gnt[1] === 1'b1,     d_gnt[1],     1'b1);
    chk("ld_we",    mem_we[1] === 1'b0,    mem_we[1],    1'b0);
    chk("ld_stall", cpu_stall[1] === 1'b0, cpu_stall[1], 1'b0);
    cyc();
    d_req[1] = 1'b0;
    smp();
    chk("l2_w1_rvalid", d_rvalid[1] === 1'b0,  d_rvalid[1],  1'b0);
    chk("l2_w1_stall",  cpu_stall[1] === 1'b1, cpu_stall[1], 1'b1);
    chk("l2_w1_gnt",    d_gnt[1] === 1'b0,     d_gnt[1],     1'b0);
    cyc();
    smp();
    chk("l2_rvalid",   d_rvalid[1] === 1'b1,          d_rvalid[1],  1'b1);
    chk("l2_rdata",    d_rdata[1] === 32'hDEAD_BEEF,  d_rdata[1],   32'hDEAD_BEEF);
    chk("l2_f_rvalid", f_rvalid[1] === 1'b0,          f_rvalid[1],  1'b0);
    chk("l2_w2_stall", cpu_stall[1] === 1'b1,         cpu_stall[1], 1'b1);
    cyc();
    smp();
    chk("l2_done_rv",    d_rvalid[1] === 1'b0,  d_rvalid[1],  1'b0);
    chk("l2_done_stall", cpu_stall[1] === 1'b0, cpu_stall[1], 1'b0);

    // RD_LAT=1: D and F contending from reset alternate, D first
    cyc();
    rst[0] = 1'b1;
    smp();
    cyc();
    rst[0] = 1'b0;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 14'h001;
    f_req[0] = 1'b1; f_addr[0] = 14'h002;
    exp_d = 8'b0001_0001;
    exp_f = 8'b0100_0100;
    for (int i = 0; i < 8; i++) begin
      smp();
      chk("rr_d_gnt", d_gnt[0] === exp_d[i],  d_gnt[0],     exp_d[i]);
      chk("rr_f_gnt", f_gnt[0] === exp_f[i],  f_gnt[0],     exp_f[i]);
      chk("rr_stall", cpu_stall[0] === 1'b1,  cpu_stall[0], 1'b1);
      cyc();
    end
    d_req[0] = 1'b0; f_req[0] = 1'b0;
    smp();
    cyc();

    // RD_LAT=1: loader burst starves a waiting fetch
    for (int k = 0; k < 4; k++) begin
      ld_req[0] = 1'b1; ld_addr[0] = 14'(k); ld_wdata[0] = 32'hA0 + 32'(k);
      f_req[0] = 1'b1; f_addr[0] = 14'h002;
      smp();
      chk("burst_ld_gnt", ld_gnt[0] === 1'b1,              ld_gnt[0],    1'b1);
      chk("burst_f_gnt",  f_gnt[0] === 1'b0,               f_gnt[0],     1'b0);
      chk("burst_we",     mem_we[0] === 1'b1,              mem_we[0],    1'b1);
      chk("burst_addr",   mem_addr[0] === 14'(k),          mem_addr[0],  14'(k));
      chk("burst_wdata",  mem_wdata[0] === 32'hA0 + 32'(k), mem_wdata[0], 32'hA0 + 32'(k));
      chk("burst_stall",  cpu_stall[0] === 1'b1,           cpu_stall[0], 1'b1);
      cyc();
    end
    ld_req[0] = 1'b0;
    smp();
    chk("post_f_gnt",  f_gnt[0] === 1'b1,       f_gnt[0],     1'b1);
    chk("post_ld_gnt", ld_gnt[0] === 1'b0,      ld_gnt[0],    1'b0);
    chk("post_addr",   mem_addr[0] === 14'h002, mem_addr[0],  14'h002);
    chk("post_stall",  cpu_stall[0] === 1'b0,   cpu_stall[0], 1'b0);
    cyc();
    f_req[0] = 1'b0;
    smp();
    chk("post_rvalid", f_rvalid[0] === 1'b1,         f_rvalid[0], 1'b1);
    chk("post_rdata",  f_rdata[0] === 32'h0000_00A2, f_rdata[0],  32'h0000_00A2);
    cyc();

    // RD_LAT=3: reset in the 2nd wait cycle aborts the read
    f_req[2] = 1'b1; f_addr[2] = 14'h020;
    smp();
    chk("l3_gnt", f_gnt[2] === 1'b1, f_gnt[2], 1'b1);
    cyc();
    f_req[2] = 1'b0;
    smp();
    chk("l3_w1_rvalid", f_rvalid[2] === 1'b0,  f_rvalid[2],  1'b0);
    chk("l3_w1_stall",  cpu_stall[2] === 1'b1, cpu_stall[2], 1'b1);
    cyc();
    rst[2] = 1'b1; f_req[2] = 1'b1; d_req[2] = 1'b1; ld_req[2] = 1'b1;
    smp();
    chk("l3_rst_f_gnt",  f_gnt[2] === 1'b0,      f_gnt[2],     1'b0);
    chk("l3_rst_ld_gnt", ld_gnt[2] === 1'b0,     ld_gnt[2],    1'b0);
    chk("l3_rst_d_gnt",  d_gnt[2] === 1'b0,      d_gnt[2],     1'b0);
    chk("l3_rst_rvalid", f_rvalid[2] === 1'b0,   f_rvalid[2],  1'b0);
    chk("l3_rst_en",     mem_en[2] === 1'b0,     mem_en[2],    1'b0);
    chk("l3_rst_addr",   mem_addr[2] === 14'h0,  mem_addr[2],  14'h0);
    chk("l3_rst_stall",  cpu_stall[2] === 1'b0,  cpu_stall[2], 1'b0);
    chk("l3_rst_rdata",  f_rdata[2] === 32'h0,   f_rdata[2],   32'h0);
    cyc();
    rst[2] = 1'b0; d_req[2] = 1'b0; ld_req[2] = 1'b0;
    smp();
    chk("l3_fresh_gnt", f_gnt[2] === 1'b1,    f_gnt[2],    1'b1);
    chk("l3_abort_rv",  f_rvalid[2] === 1'b0, f_rvalid[2], 1'b0);
    cyc();
    f_req[2] = 1'b0;
    smp();
    chk("l3_n1_rvalid", f_rvalid[2] === 1'b0, f_rvalid[2], 1'b0);
    cyc();
    smp();
    chk("l3_n2_rvalid", f_rvalid[2] === 1'b0, f_rvalid[2], 1'b0);
    cyc();
    smp();
    chk("l3_n3_rvalid", f_rvalid[2] === 1'b1, f_rvalid[2], 1'b1);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
